// File: rtl/vga_draw_arbiter_pkg.sv
// Shared types and constants for the VGA draw arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the screen geometry, requester IDs, arbiter state encoding and the
// pixel struct that travels from a draw engine to the vga_adapter port.
package vga_draw_arbiter_pkg;

   localparam int nX          = 10;
   localparam int nY          = 9;
   localparam int COLOR_DEPTH = 9;
   localparam int XMAX        = 640;
   localparam int YMAX        = 480;

   // Requester index assignment on the shared pixel port.
   localparam int REQ_OBSTACLE = 0;
   localparam int REQ_PLAYER   = 1;
   localparam int REQ_HUD      = 2;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [nX-1:0]          x;
      logic [nY-1:0]          y;
      logic [COLOR_DEPTH-1:0] color;
   } pixel_t;

   // Screen limits sized to the coordinate buses so compares stay width-exact.
   localparam logic [31:0]   XMAX_W  = XMAX;
   localparam logic [31:0]   YMAX_W  = YMAX;
   localparam logic [nX-1:0] XMAX_C  = XMAX_W[nX-1:0];
   localparam logic [nY-1:0] YMAX_C  = YMAX_W[nY-1:0];

   // A pixel lands on screen only when both coordinates are inside the frame.
   function automatic logic pix_on_screen(input pixel_t p);
      return (p.x < XMAX_C) && (p.y < YMAX_C);
   endfunction

endpackage

// File: rtl/vga_draw_arbiter_if.sv
// Request-side bundle between the draw engines and the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; gnt is the only signal flowing back to the engines.
//
// master : draw engines (drive req/valid/last/pixel buses, observe gnt)
// slave  : arbiter      (observe requests, drive one-hot gnt)
// Pixel buses are packed per requester: requester i at [i*w +: w].
interface vga_draw_arbiter_if
   import vga_draw_arbiter_pkg::*;
#(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]             req;
   logic [NREQ-1:0]             valid;
   logic [NREQ-1:0]             last;
   logic [NREQ*nX-1:0]          x_in;
   logic [NREQ*nY-1:0]          y_in;
   logic [NREQ*COLOR_DEPTH-1:0] color_in;
   logic [NREQ-1:0]             gnt;

   modport master (
      output req, valid, last, x_in, y_in, color_in,
      input  gnt
   );

   modport slave (
      input  req, valid, last, x_in, y_in, color_in,
      output gnt
   );
endinterface

// File: rtl/rr_priority_picker.sv
// Picks one winner from a request vector, rotating or fixed priority.
// Latency: combinational.
// Backpressure: none.
//
// req_i    : pending requests
// ptr_i    : index of the previous winner (rotating mode starts at ptr_i+1)
// win_o    : one-hot winner, zero when nothing is requested
// win_id_o : winner index
// any_o    : at least one request is pending
module rr_priority_picker #(
   parameter int  NREQ        = 3,
   parameter bit  ROUND_ROBIN = 1'b1,
   localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
)(
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic [IDW-1:0]  win_id_o,
   output logic            any_o
);

   logic [IDW-1:0] idx;

   always_comb begin
      win_o    = '0;
      win_id_o = '0;
      idx      = '0;
      any_o    = |req_i;
      // Scan from the farthest candidate towards the nearest; the last hit
      // written is therefore the highest-priority one.
      for (int k = NREQ; k >= 1; k--) begin
         if (ROUND_ROBIN)
            idx = IDW'((int'(ptr_i) + k) % NREQ);
         else
            idx = IDW'(k - 1);
         if (req_i[idx])
            win_id_o = idx;
      end
      win_o[win_id_o] = any_o;
   end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the vga_adapter pixel port between draw engines, one whole burst at a time.
// Latency: grant 1 cycle after req; pixel 1 cycle after valid; one idle bubble between bursts.
// Backpressure: none; the granted engine's pixel is taken the cycle it is presented.
//
// Ports: Clock / Resetn (synchronous, active-low); bus = request bundle (slave side,
// drives gnt); active_id / busy = current owner; VGA_* = registered pixel write to
// vga_adapter; timeout_pulse = grant revoked by idle timeout; clip_pulse = granted
// pixel dropped for lying off screen.
module vga_draw_arbiter
   import vga_draw_arbiter_pkg::*;
#(
   parameter int  NREQ        = 3,
   parameter bit  ROUND_ROBIN = 1'b1,
   parameter int  TIMEOUT     = 1024,
   localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW          = $clog2(TIMEOUT) + 1
)(
   input  logic                   Clock,
   input  logic                   Resetn,
   vga_draw_arbiter_if.slave      bus,
   output logic [IDW-1:0]         active_id,
   output logic                   busy,
   output logic [nX-1:0]          VGA_x,
   output logic [nY-1:0]          VGA_y,
   output logic [COLOR_DEPTH-1:0] VGA_color,
   output logic                   VGA_write,
   output logic                   timeout_pulse,
   output logic                   clip_pulse
);

   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   // The burst is revoked on the idle cycle that would bring the count to TIMEOUT-1.
   localparam logic [CW-1:0] CNT_TRIP = CW'(TIMEOUT - 2);

   arb_state_e      state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;
   pixel_t          px_q, px_d;
   logic            wr_q, wr_d;
   logic            tp_q, tp_d;
   logic            cp_q, cp_d;

   logic [NREQ-1:0] win;
   logic [IDW-1:0]  win_id;
   logic            any_req;

   pixel_t          pix_w;
   logic            v_w, l_w, r_w;
   logic            timeout_hit;

   rr_priority_picker #(
      .NREQ        (NREQ),
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_picker (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .win_o    (win),
      .win_id_o (win_id),
      .any_o    (any_req)
   );

   // Select the current owner's lane; other requesters are invisible during a burst.
   always_comb begin
      pix_w = '0;
      v_w   = 1'b0;
      l_w   = 1'b0;
      r_w   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (id_q == IDW'(i)) begin
            pix_w.x     = bus.x_in[i*nX +: nX];
            pix_w.y     = bus.y_in[i*nY +: nY];
            pix_w.color = bus.color_in[i*COLOR_DEPTH +: COLOR_DEPTH];
            v_w         = bus.valid[i];
            l_w         = bus.last[i];
            r_w         = bus.req[i];
         end
      end
   end

   // Needs valid low, so it can never coincide with a last beat.
   assign timeout_hit = ~v_w & (cnt_q == CNT_TRIP);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      px_d    = px_q;
      wr_d    = 1'b0;
      tp_d    = 1'b0;
      cp_d    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (any_req) begin
               state_d = ARB_BURST;
               gnt_d   = win;
               id_d    = win_id;
               ptr_d   = win_id;
               busy_d  = 1'b1;
            end
         end
         ARB_BURST: begin
            if (v_w) begin
               cnt_d = '0;
               if (pix_on_screen(pix_w)) begin
                  wr_d = 1'b1;
                  px_d = pix_w;
               end else begin
                  cp_d = 1'b1;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            tp_d = timeout_hit;
            // Burst ends on last beat, on req withdrawn, or on idle timeout.
            if ((v_w && l_w) || !r_w || timeout_hit) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= ARB_IDLE;
         ptr_q   <= IDW'(NREQ - 1);
         id_q    <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         px_q    <= '0;
         wr_q    <= 1'b0;
         tp_q    <= 1'b0;
         cp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         px_q    <= px_d;
         wr_q    <= wr_d;
         tp_q    <= tp_d;
         cp_q    <= cp_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign active_id     = id_q;
   assign busy          = busy_q;
   assign VGA_x         = px_q.x;
   assign VGA_y         = px_q.y;
   assign VGA_color     = px_q.color;
   assign VGA_write     = wr_q;
   assign timeout_pulse = tp_q;
   assign clip_pulse    = cp_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: a rotating-priority and a fixed-priority instance
// share one stimulus stream and are both compared every cycle against a
// behavioural model; directed phases add fixed expected values.
`timescale 1ns/1ps
module tb_vga_draw_arbiter;
   import vga_draw_arbiter_pkg::*;

   localparam int NREQ = 3;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic                   rstn;
   logic [NREQ-1:0]        rq, vl, ls;
   logic [nX-1:0]          xs [NREQ];
   logic [nY-1:0]          ys [NREQ];
   logic [COLOR_DEPTH-1:0] cs [NREQ];

   vga_draw_arbiter_if #(.NREQ(NREQ)) ifa ();
   vga_draw_arbiter_if #(.NREQ(NREQ)) ifb ();

   assign ifa.req      = rq;
   assign ifa.valid    = vl;
   assign ifa.last     = ls;
   assign ifa.x_in     = {xs[2], xs[1], xs[0]};
   assign ifa.y_in     = {ys[2], ys[1], ys[0]};
   assign ifa.color_in = {cs[2], cs[1], cs[0]};
   assign ifb.req      = rq;
   assign ifb.valid    = vl;
   assign ifb.last     = ls;
   assign ifb.x_in     = {xs[2], xs[1], xs[0]};
   assign ifb.y_in     = {ys[2], ys[1], ys[0]};
   assign ifb.color_in = {cs[2], cs[1], cs[0]};

   logic [1:0]             aid [2];
   logic                   bz  [2];
   logic [nX-1:0]          vx  [2];
   logic [nY-1:0]          vy  [2];
   logic [COLOR_DEPTH-1:0] vc  [2];
   logic                   vw  [2];
   logic                   tp  [2];
   logic                   cp  [2];

   vga_draw_arbiter #(.NREQ(NREQ), .ROUND_ROBIN(1'b1), .TIMEOUT(TMO)) dut_rr (
      .Clock(clk), .Resetn(rstn), .bus(ifa),
      .active_id(aid[0]), .busy(bz[0]), .VGA_x(vx[0]), .VGA_y(vy[0]),
      .VGA_color(vc[0]), .VGA_write(vw[0]), .timeout_pulse(tp[0]), .clip_pulse(cp[0])
   );

   vga_draw_arbiter #(.NREQ(NREQ), .ROUND_ROBIN(1'b0), .TIMEOUT(TMO)) dut_fp (
      .Clock(clk), .Resetn(rstn), .bus(ifb),
      .active_id(aid[1]), .busy(bz[1]), .VGA_x(vx[1]), .VGA_y(vy[1]),
      .VGA_color(vc[1]), .VGA_write(vw[1]), .timeout_pulse(tp[1]), .clip_pulse(cp[1])
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: owner, rotation pointer and idle run length per instance
   // (index 0 rotating, index 1 fixed priority).
   int m_busy [2], m_own [2], m_ptr [2], m_idle [2], m_aid [2], m_gnt [2];
   int m_wr [2], m_x [2], m_y [2], m_c [2], m_tp [2], m_cp [2];

   task automatic model_step(input int d);
      int w;
      int i;
      bit v;
      if (!rstn) begin
         m_busy[d] = 0; m_own[d] = 0; m_ptr[d] = NREQ - 1; m_idle[d] = 0;
         m_aid[d] = 0; m_gnt[d] = 0; m_wr[d] = 0; m_x[d] = 0; m_y[d] = 0;
         m_c[d] = 0; m_tp[d] = 0; m_cp[d] = 0;
         return;
      end
      m_wr[d] = 0; m_tp[d] = 0; m_cp[d] = 0;
      if (m_busy[d] == 0) begin
         w = -1;
         for (int k = 1; k <= NREQ; k++) begin
            i = (d == 0) ? (m_ptr[d] + k) % NREQ : k - 1;
            if (w < 0 && rq[i]) w = i;
         end
         if (w >= 0) begin
            m_busy[d] = 1; m_own[d] = w; m_aid[d] = w; m_ptr[d] = w;
            m_gnt[d] = 1 << w; m_idle[d] = 0;
         end
      end else begin
         w = m_own[d];
         v = vl[w];
         if (v) begin
            if (int'(xs[w]) < XMAX && int'(ys[w]) < YMAX) begin
               m_wr[d] = 1; m_x[d] = int'(xs[w]); m_y[d] = int'(ys[w]); m_c[d] = int'(cs[w]);
            end else begin
               m_cp[d] = 1;
            end
            m_idle[d] = 0;
         end else begin
            m_idle[d] = m_idle[d] + 1;
         end
         m_tp[d] = (!v && m_idle[d] == TMO - 1) ? 1 : 0;
         if ((v && ls[w]) || !rq[w] || m_tp[d] == 1) begin
            m_busy[d] = 0; m_gnt[d] = 0;
         end
      end
   endtask

   function automatic logic [NREQ-1:0] gnt_of(input int d);
      return (d == 0) ? ifa.gnt : ifb.gnt;
   endfunction

   task automatic compare_all();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("gnt[%0d]", d),   32'(gnt_of(d)), m_gnt[d]);
         check($sformatf("busy[%0d]", d),  32'(bz[d]),     m_busy[d]);
         check($sformatf("aid[%0d]", d),   32'(aid[d]),    m_aid[d]);
         check($sformatf("write[%0d]", d), 32'(vw[d]),     m_wr[d]);
         check($sformatf("x[%0d]", d),     32'(vx[d]),     m_x[d]);
         check($sformatf("y[%0d]", d),     32'(vy[d]),     m_y[d]);
         check($sformatf("color[%0d]", d), 32'(vc[d]),     m_c[d]);
         check($sformatf("tmo[%0d]", d),   32'(tp[d]),     m_tp[d]);
         check($sformatf("clip[%0d]", d),  32'(cp[d]),     m_cp[d]);
      end
   endtask

   // One clock: model advances on the edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      compare_all();
   endtask

   int exp_rr [4] = '{0, 1, 2, 0};
   int pv;

   initial begin
      rstn = 1'b0; rq = '0; vl = '0; ls = '0;
      for (int i = 0; i < NREQ; i++) begin xs[i] = '0; ys[i] = '0; cs[i] = '0; end
      tick();
      tick();
      check("reset_gnt", 32'(ifa.gnt), 0);
      check("reset_write", 32'(vw[0]), 0);

      // Two requesters: 0 first, one idle bubble, then 1.
      rstn = 1'b1; rq = 3'b011;
      tick();
      check("t1_first_gnt", 32'(ifa.gnt), 32'h1);
      vl = 3'b001; ls = 3'b001; xs[0] = 10'd10; ys[0] = 9'd20; cs[0] = 9'h055;
      tick();
      check("t1_bubble_gnt", 32'(ifa.gnt), 0);
      check("t1_last_write", 32'(vw[0]), 1);
      rq = 3'b010; vl = '0; ls = '0;
      tick();
      check("t1_second_gnt", 32'(ifa.gnt), 32'h2);

      // Owner 1 writes while requester 0 pulses valid and keeps req pending.
      rq = 3'b011; vl = 3'b011; xs[1] = 10'd100; ys[1] = 9'd360; cs[1] = 9'h1C0; xs[0] = 10'd5;
      tick();
      check("t2_write", 32'(vw[0]), 1);
      check("t2_x", 32'(vx[0]), 100);
      check("t2_y", 32'(vy[0]), 360);
      check("t2_color", 32'(vc[0]), 32'h1C0);
      vl = 3'b001;
      tick();
      check("t3_foreign_write", 32'(vw[0]), 0);
      check("t3_x_hold", 32'(vx[0]), 100);

      // Off-screen pixel is dropped, the corner pixel is written and ends the burst.
      vl = 3'b010; xs[1] = 10'd700; ys[1] = 9'd10;
      tick();
      check("t4_clip_write", 32'(vw[0]), 0);
      check("t4_clip_pulse", 32'(cp[0]), 1);
      xs[1] = 10'd639; ys[1] = 9'd479; ls = 3'b010;
      tick();
      check("t4_corner_write", 32'(vw[0]), 1);
      check("t4_corner_x", 32'(vx[0]), 639);
      check("t4_corner_y", 32'(vy[0]), 479);
      rq = 3'b001; vl = '0; ls = '0;
      tick();
      check("t3_pending_gnt", 32'(ifa.gnt), 32'h1);
      vl = 3'b001; ls = 3'b001; xs[0] = 10'd1; ys[0] = 9'd1;
      tick();
      rq = '0; vl = '0; ls = '0;
      tick();

      // Idle timeout on requester 2.
      rq = 3'b100;
      tick();
      check("t5_gnt", 32'(ifa.gnt), 32'h4);
      for (int k = 1; k <= TMO - 1; k++) begin
         tick();
         if (k < TMO - 1) begin
            check("t5_no_tmo", 32'(tp[0]), 0);
            check("t5_busy", 32'(bz[0]), 1);
         end else begin
            check("t5_tmo", 32'(tp[0]), 1);
            check("t5_gnt_clr", 32'(ifa.gnt), 0);
            check("t5_busy_clr", 32'(bz[0]), 0);
         end
      end
      rq = '0;
      tick();

      // Everyone requesting, two-beat bursts: rotation vs fixed priority.
      rq = 3'b111; vl = 3'b111;
      for (int c = 0; c < 12; c++) begin
         ls = (c % 3 == 2) ? 3'b111 : 3'b000;
         tick();
         if (c % 3 == 0) begin
            check("t6_rr_order", 32'(ifa.gnt), 32'(1 << exp_rr[c / 3]));
            check("t6_fixed_order", 32'(ifb.gnt), 32'h1);
         end
      end
      ls = '0;
      tick();
      rstn = 1'b0;
      tick();
      check("t6_rst_gnt", 32'(ifa.gnt), 0);
      check("t6_rst_write", 32'(vw[0]), 0);
      rstn = 1'b1; rq = '0; vl = '0;
      tick();

      // Random traffic with phases of sparse valid to provoke timeouts.
      pv = 2;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) pv = $urandom_range(0, 4);
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 15) == 0) rq[i] = ~rq[i];
            vl[i] = ($urandom_range(0, 3) < pv);
            ls[i] = ($urandom_range(0, 3) == 0);
            xs[i] = nX'($urandom_range(0, 700));
            ys[i] = nY'($urandom_range(0, 511));
            cs[i] = COLOR_DEPTH'($urandom);
         end
         rstn = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
